axi_eth_rx_frame_filter: RTL and testbench

Single-clock, parametrised store-and-forward RX frame filter for the 10G Ethernet receive path. It buffers each frame from the MAC receive AXI-Stream into an internal RAM and forwards only complete good frames to the downstream mac_* stream. Frames are dropped when flagged bad by tuser, when they overflow the buffer, or when they exceed a maximum length. Optional saturating statistics counters are provided.

---
 rtl/axi_eth_rx_frame_filter_pkg.sv | 16 +
 rtl/axi_eth_sdp_ram.sv | 35 +++
 rtl/axi_eth_rx_frame_filter.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_eth_rx_frame_filter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_eth_rx_frame_filter_pkg.sv
// Shared definitions for the RX frame filter: input FSM state encoding,
// statistics counter width and buffer word width.
package axi_eth_rx_frame_filter_pkg;

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam int STAT_W = 32;

    // Buffer word is {tlast, tkeep, tdata}.
    function automatic int buf_word_width(input int data_w, input int keep_w);
        return data_w + keep_w + 1;
    endfunction

endpackage

// File: rtl/axi_eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enabled read. The read data register holds while rd_en is low.
module axi_eth_sdp_ram #(
    parameter int C_WIDTH      = 8,
    parameter int C_ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [C_ADDR_WIDTH-1:0] wr_addr,
    input  logic [C_WIDTH-1:0]      wr_data,
    input  logic                    rd_en,
    input  logic [C_ADDR_WIDTH-1:0] rd_addr,
    output logic [C_WIDTH-1:0]      rd_data
);

    logic [C_WIDTH-1:0] mem_q [2**C_ADDR_WIDTH];
    logic [C_WIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Synchronous read, held when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_eth_rx_frame_filter.sv
// Store-and-forward RX frame filter. Frames are buffered and only released
// downstream once their tlast arrives without tuser, overflow or oversize.
// Build option: AXI_ETH_RX_FILTER_STATS_EN enables the saturating
// stat_good / stat_bad / stat_drop counters; otherwise they read as 0.
//
// state | meaning
// SYNC  | after reset: discard until an idle cycle or a frame end
// PASS  | store beats of the current frame
// DROP  | current frame overflowed/too long: discard until its tlast
module axi_eth_rx_frame_filter
    import axi_eth_rx_frame_filter_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_KEEP_WIDTH = C_DATA_WIDTH / 8,
    parameter int C_ADDR_WIDTH = 9,
    parameter int C_MAX_BEATS  = 1200
) (
    input  logic                    rx_clk,
    input  logic                    rx_reset,
    input  logic [C_DATA_WIDTH-1:0] rx_axis_mac_tdata,
    input  logic [C_KEEP_WIDTH-1:0] rx_axis_mac_tkeep,
    input  logic                    rx_axis_mac_tlast,
    input  logic                    rx_axis_mac_tuser,
    input  logic                    rx_axis_mac_tvalid,
    output logic                    rx_axis_mac_tready,
    output logic [C_DATA_WIDTH-1:0] mac_tdata,
    output logic [C_KEEP_WIDTH-1:0] mac_tkeep,
    output logic                    mac_tlast,
    output logic                    mac_tvalid,
    input  logic                    mac_tready,
    output logic [STAT_W-1:0]       stat_good,
    output logic [STAT_W-1:0]       stat_bad,
    output logic [STAT_W-1:0]       stat_drop
);

    localparam int W_W = buf_word_width(C_DATA_WIDTH, C_KEEP_WIDTH);
    localparam int P_W = C_ADDR_WIDTH + 1;
    localparam int B_W = $clog2(C_MAX_BEATS + 1);
    localparam logic [P_W-1:0] DEPTH = {1'b1, {C_ADDR_WIDTH{1'b0}}};

    logic [1:0]     state_q, state_d;
    logic [P_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [P_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [B_W-1:0] beat_cnt_q, beat_cnt_d;
    logic           bad_q, bad_d;
    logic           ram_vld_q, ram_vld_d;
    logic           out_vld_q, out_vld_d;
    logic [W_W-1:0] out_word_q, out_word_d;

    logic           accept;
    logic [P_W-1:0] used;
    logic           no_room;
    logic           wr_en;
    logic [W_W-1:0] wr_word;
    logic           rd_en;
    logic           load_out;
    logic [W_W-1:0] ram_rdata;
    logic           inc_good, inc_bad, inc_drop;

    // The MAC is never back-pressured outside reset.
    assign rx_axis_mac_tready = ~rx_reset;
    assign accept  = rx_axis_mac_tvalid & rx_axis_mac_tready;
    assign used    = wr_ptr_q - rd_ptr_q;
    assign no_room = (used == DEPTH) || (beat_cnt_q >= B_W'(C_MAX_BEATS));
    assign wr_word = {rx_axis_mac_tlast, rx_axis_mac_tkeep, rx_axis_mac_tdata};

    // Input FSM: store, commit, roll back or drop the incoming frame.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        bad_d        = bad_q;
        wr_en        = 1'b0;
        inc_good     = 1'b0;
        inc_bad      = 1'b0;
        inc_drop     = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (!rx_axis_mac_tvalid || (accept && rx_axis_mac_tlast)) begin
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (accept) begin
                    if (no_room) begin
                        // Overflow/oversize wins over tuser so a frame is counted once.
                        wr_ptr_d   = commit_ptr_q;
                        beat_cnt_d = '0;
                        bad_d      = 1'b0;
                        if (rx_axis_mac_tlast) begin
                            inc_drop = 1'b1;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else if (rx_axis_mac_tlast) begin
                        beat_cnt_d = '0;
                        bad_d      = 1'b0;
                        if (bad_q || rx_axis_mac_tuser) begin
                            wr_ptr_d = commit_ptr_q;
                            inc_bad  = 1'b1;
                        end else begin
                            wr_en        = 1'b1;
                            wr_ptr_d     = wr_ptr_q + P_W'(1);
                            commit_ptr_d = wr_ptr_q + P_W'(1);
                            inc_good     = 1'b1;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + P_W'(1);
                        beat_cnt_d = beat_cnt_q + B_W'(1);
                        bad_d      = bad_q | rx_axis_mac_tuser;
                    end
                end
            end
            ST_DROP: begin
                if (accept && rx_axis_mac_tlast) begin
                    inc_drop   = 1'b1;
                    beat_cnt_d = '0;
                    bad_d      = 1'b0;
                    state_d    = ST_PASS;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // Read side: RAM output register feeds a one-entry output register.
    always_comb begin
        load_out   = ram_vld_q & (~out_vld_q | mac_tready);
        rd_en      = (rd_ptr_q != commit_ptr_q) & (~ram_vld_q | load_out);
        rd_ptr_d   = rd_en ? rd_ptr_q + P_W'(1) : rd_ptr_q;
        ram_vld_d  = rd_en | (ram_vld_q & ~load_out);
        out_vld_d  = load_out | (out_vld_q & ~mac_tready);
        out_word_d = load_out ? ram_rdata : out_word_q;
    end

    // State, pointer and output registers.
    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            state_q      <= ST_SYNC;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            bad_q        <= 1'b0;
            ram_vld_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            bad_q        <= bad_d;
            ram_vld_q    <= ram_vld_d;
            out_vld_q    <= out_vld_d;
            out_word_q   <= out_word_d;
        end
    end

    axi_eth_sdp_ram #(
        .C_WIDTH      (W_W),
        .C_ADDR_WIDTH (C_ADDR_WIDTH)
    ) u_ram (
        .clk     (rx_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[C_ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[C_ADDR_WIDTH-1:0]),
        .rd_data (ram_rdata)
    );

    assign mac_tdata  = out_word_q[C_DATA_WIDTH-1:0];
    assign mac_tkeep  = out_word_q[C_DATA_WIDTH +: C_KEEP_WIDTH];
    assign mac_tlast  = out_word_q[W_W-1];
    assign mac_tvalid = out_vld_q;

`ifdef AXI_ETH_RX_FILTER_STATS_EN
    logic [STAT_W-1:0] stat_good_q, stat_good_d;
    logic [STAT_W-1:0] stat_bad_q, stat_bad_d;
    logic [STAT_W-1:0] stat_drop_q, stat_drop_d;

    // Saturating frame counters.
    always_comb begin
        stat_good_d = stat_good_q;
        stat_bad_d  = stat_bad_q;
        stat_drop_d = stat_drop_q;
        if (inc_good && (stat_good_q != '1)) stat_good_d = stat_good_q + STAT_W'(1);
        if (inc_bad  && (stat_bad_q  != '1)) stat_bad_d  = stat_bad_q  + STAT_W'(1);
        if (inc_drop && (stat_drop_q != '1)) stat_drop_d = stat_drop_q + STAT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            stat_good_q <= '0;
            stat_bad_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_good_q <= stat_good_d;
            stat_bad_q  <= stat_bad_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_good = stat_good_q;
    assign stat_bad  = stat_bad_q;
    assign stat_drop = stat_drop_q;
`else
    logic unused_stats;
    assign unused_stats = inc_good ^ inc_bad ^ inc_drop;
    assign stat_good    = '0;
    assign stat_bad     = '0;
    assign stat_drop    = '0;
`endif

endmodule

// File: tb/tb_axi_eth_rx_frame_filter.sv
// Scoreboard bench for axi_eth_rx_frame_filter: stimulus pushes expected
// beats, a forked monitor pops and compares every output handshake.
module tb_axi_eth_rx_frame_filter;

    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int AW   = 9;
    localparam int MAXB = 1200;
    localparam int WW   = DW + KW + 1;
`ifdef AXI_ETH_RX_FILTER_STATS_EN
    localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STAT_MASK = 32'h0;
`endif

    logic          rx_clk = 1'b0;
    logic          rx_reset;
    logic [DW-1:0] rx_axis_mac_tdata;
    logic [KW-1:0] rx_axis_mac_tkeep;
    logic          rx_axis_mac_tlast;
    logic          rx_axis_mac_tuser;
    logic          rx_axis_mac_tvalid;
    logic          rx_axis_mac_tready;
    logic [DW-1:0] mac_tdata;
    logic [KW-1:0] mac_tkeep;
    logic          mac_tlast;
    logic          mac_tvalid;
    logic          mac_tready;
    logic [31:0]   stat_good, stat_bad, stat_drop;

    always #5 rx_clk = ~rx_clk;

    axi_eth_rx_frame_filter #(
        .C_DATA_WIDTH (DW),
        .C_ADDR_WIDTH (AW),
        .C_MAX_BEATS  (MAXB)
    ) dut (
        .rx_clk             (rx_clk),
        .rx_reset           (rx_reset),
        .rx_axis_mac_tdata  (rx_axis_mac_tdata),
        .rx_axis_mac_tkeep  (rx_axis_mac_tkeep),
        .rx_axis_mac_tlast  (rx_axis_mac_tlast),
        .rx_axis_mac_tuser  (rx_axis_mac_tuser),
        .rx_axis_mac_tvalid (rx_axis_mac_tvalid),
        .rx_axis_mac_tready (rx_axis_mac_tready),
        .mac_tdata          (mac_tdata),
        .mac_tkeep          (mac_tkeep),
        .mac_tlast          (mac_tlast),
        .mac_tvalid         (mac_tvalid),
        .mac_tready         (mac_tready),
        .stat_good          (stat_good),
        .stat_bad           (stat_bad),
        .stat_drop          (stat_drop)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_good = 0, exp_bad = 0, exp_drop = 0;
    logic [WW-1:0] exp_q[$];
    bit rand_on;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string name);
        check({name, "_good"}, 128'(stat_good), 128'(32'(exp_good) & STAT_MASK));
        check({name, "_bad"},  128'(stat_bad),  128'(32'(exp_bad)  & STAT_MASK));
        check({name, "_drop"}, 128'(stat_drop), 128'(32'(exp_drop) & STAT_MASK));
    endtask

    task automatic mon_loop();
        logic [WW-1:0] cur_w, prev_w, exp_w;
        bit prev_stall;
        prev_stall = 1'b0;
        prev_w     = '0;
        forever begin
            @(negedge rx_clk);
            cur_w = {mac_tlast, mac_tkeep, mac_tdata};
            if (rx_reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", 128'({mac_tvalid, cur_w}), 128'({1'b1, prev_w}));
                if (mac_tvalid && mac_tready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %0h, expected no beat", cur_w);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("beat", 128'(cur_w), 128'(exp_w));
                    end
                end
                prev_stall = mac_tvalid && !mac_tready;
                prev_w     = cur_w;
            end
        end
    endtask

    // Drives one frame; tvalid is left high so frames can run back to back.
    task automatic send_frame(input int fid, input int nb, input logic [7:0] lkeep,
                              input bit bad_last, input bit good, input bit rnd, input int gap);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        bit            l;
        for (int i = 0; i < nb; i++) begin
            d = rnd ? {$urandom, $urandom} : {32'(fid), 32'(i)};
            l = (i == nb - 1);
            k = l ? lkeep : 8'hFF;
            if (good) exp_q.push_back({l, k, d});
            rx_axis_mac_tdata  = d;
            rx_axis_mac_tkeep  = k;
            rx_axis_mac_tlast  = l;
            rx_axis_mac_tuser  = bad_last && l;
            rx_axis_mac_tvalid = 1'b1;
            @(posedge rx_clk); #1;
            if (gap > 0) begin
                rx_axis_mac_tvalid = 1'b0;
                repeat ($urandom_range(gap, gap + 2)) @(posedge rx_clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        rx_axis_mac_tvalid = 1'b0;
        rx_axis_mac_tlast  = 1'b0;
        rx_axis_mac_tuser  = 1'b0;
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            @(posedge rx_clk);
            c++;
        end
        #1;
        repeat (8) @(posedge rx_clk);
        #1;
        check(name, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic reset_checks(input string name);
        @(negedge rx_clk);
        check({name, "_tvalid"}, 128'(mac_tvalid), 128'(0));
        check({name, "_tready"}, 128'(rx_axis_mac_tready), 128'(0));
        check({name, "_data"},   128'({mac_tlast, mac_tkeep, mac_tdata}), 128'(0));
        check({name, "_stats"},  128'({stat_good, stat_bad, stat_drop}), 128'(0));
    endtask

    initial begin
        int cnt;
        rx_reset           = 1'b1;
        rx_axis_mac_tdata  = '0;
        rx_axis_mac_tkeep  = '0;
        rx_axis_mac_tlast  = 1'b0;
        rx_axis_mac_tuser  = 1'b0;
        rx_axis_mac_tvalid = 1'b0;
        mac_tready         = 1'b1;
        fork
            mon_loop();
        join_none
        repeat (3) @(posedge rx_clk);
        #1;
        reset_checks("rst0");
        @(posedge rx_clk); #1;
        rx_reset = 1'b0;
        idle(2);
        check("tready_run", 128'(rx_axis_mac_tready), 128'(1));

        // 8-beat good frame: latency 2 cycles after tlast, then 8 back-to-back beats.
        send_frame(1, 8, 8'h0F, 0, 1, 0, 0);
        rx_axis_mac_tvalid = 1'b0;
        rx_axis_mac_tlast  = 1'b0;
        @(negedge rx_clk); check("lat_c1", 128'(mac_tvalid), 128'(0));
        @(negedge rx_clk); check("lat_c2", 128'(mac_tvalid), 128'(0));
        @(negedge rx_clk); check("lat_c3", 128'(mac_tvalid), 128'(1));
        cnt = 0;
        while (mac_tvalid && cnt < 20) begin
            cnt++;
            @(negedge rx_clk);
        end
        check("burst_len", 128'(cnt), 128'(8));
        @(posedge rx_clk); #1;
        exp_good++;
        drain("t1_drain");
        check_stats("t1");

        // tuser on tlast, then a good 4-beat frame.
        send_frame(2, 3, 8'hFF, 1, 0, 0, 0);
        send_frame(3, 4, 8'h01, 0, 1, 0, 0);
        idle(1);
        exp_bad++;
        exp_good++;
        drain("t2_drain");
        check_stats("t2");

        // Stalled output: ten 60-beat frames, the last two overflow.
        mac_tready = 1'b0;
        for (int f = 0; f < 10; f++) send_frame(10 + f, 60, 8'hFF, 0, f < 8, 0, 0);
        idle(4);
        exp_good += 8;
        exp_drop += 2;
        check_stats("t3");
        mac_tready = 1'b1;
        drain("t3_drain");

        // 1201-beat frame is dropped, following 2-beat frame passes.
        send_frame(30, MAXB + 1, 8'hFF, 0, 0, 0, 0);
        send_frame(31, 2, 8'h3F, 0, 1, 0, 0);
        idle(1);
        exp_drop++;
        exp_good++;
        drain("t4_drain");
        check_stats("t4");

        // Reset released mid-frame with tvalid held.
        rx_reset           = 1'b1;
        rx_axis_mac_tdata  = 64'hDEAD_0000_0000_0000;
        rx_axis_mac_tkeep  = 8'hFF;
        rx_axis_mac_tlast  = 1'b0;
        rx_axis_mac_tvalid = 1'b1;
        repeat (5) @(posedge rx_clk);
        #1;
        reset_checks("rst1");
        @(posedge rx_clk); #1;
        rx_reset = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        exp_drop = 0;
        send_frame(50, 5, 8'hFF, 0, 0, 0, 0);
        idle(3);
        send_frame(51, 3, 8'h03, 0, 1, 0, 0);
        idle(1);
        exp_good++;
        drain("t5_drain");
        check_stats("t5");

        // 100 random good frames with random output stalls.
        rand_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    send_frame(100 + f, $urandom_range(1, 16), 8'(1 << $urandom_range(0, 7)),
                               0, 1, 1, 2);
                    exp_good++;
                end
                idle(1);
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge rx_clk); #1;
                    mac_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        mac_tready = 1'b1;
        drain("t6_drain");
        check_stats("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
